// File: rtl/fetch_pkg.sv
// fetch_pkg: shared front-end widths and the {pc, instr} fetch entry type.
//   PC_W          program-counter width
//   INSTR_W       instruction width
//   fetch_entry_t packed {pc, instr} pair stored by the fetch queue
package fetch_pkg;
   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between the icache and decode, with icache stall and skid margin.
//   clk, rst                     clock, synchronous active-high reset
//   flush                        redirect: drop all entries and the same-cycle fetch
//   in_valid, in_pc, in_instr    icache output word
//   fetch_stall                  stall to icache/PC stage (from registered count only)
//   out_valid, out_pc, out_instr head entry presented to decode
//   out_ready                    decode accepts the head this cycle
//   count                        occupancy
//   overflow                     sticky: a push was dropped because the queue was full
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the input straight to the
// output when the queue is empty (zero-cycle latency).
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int SKID    = 1,
   parameter int PC_W    = fetch_pkg::PC_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       fetch_stall,
   output logic                       out_valid,
   output logic [PC_W-1:0]            out_pc,
   output logic [INSTR_W-1:0]         out_instr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SKID);

   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  in_ent, head;
   logic          byp, full, pop, push, wr_en, rd_en;

   always_comb begin
      in_ent = '{pc: in_pc, instr: in_instr};
      full   = count_q == FULL;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp    = count_q == '0 && in_valid && !flush;
`else
      byp    = 1'b0;
`endif
      head      = byp ? in_ent : mem_q[rd_q];
      out_valid = count_q != '0 || byp;
      // Gate the data so an empty queue presents zeros rather than stale storage.
      out_pc    = out_valid ? head.pc : '0;
      out_instr = out_valid ? head.instr : '0;
      pop       = out_valid && out_ready;
      push      = in_valid && (!full || pop);
      // A bypassed word consumed the same cycle never touches storage.
      wr_en     = push && !flush && !(byp && out_ready);
      rd_en     = pop && !flush && !byp;
      rd_d      = rd_en ? rd_q + PW'(1) : rd_q;
      wr_d      = wr_en ? wr_q + PW'(1) : wr_q;
      count_d   = count_q + CW'(wr_en) - CW'(rd_en);
      overflow_d = overflow_q || (in_valid && full && !pop && !flush);
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_q] <= in_ent;
   end

   assign fetch_stall = count_q >= STALL_AT;
   assign count       = count_q;
   assign overflow    = overflow_q;
endmodule
